accum_feeder: RTL and testbench
===============================

// Module: accum_feeder
// PURPOSE
//  Initiator side of the enable/value accumulate interface. Buffers words from an
//  upstream valid/ready source and issues them to the 3-state accumulator one at
//  a time: a one-cycle enable pulse, with value held stable until the accumulator
//  has added it. Keeps a shadow copy of the accumulator's count so the system and
//  the bench can check the downstream result.
// PARAMETERS
//  DW     32  data width of value and shadow count
//  DEPTH  8   buffer entries; power of two, >=2
//  HOLD   2   cycles value is held after the enable cycle (accumulator adds on last)
// PORTS
//  CLK        in   1      single clock, all state on rising edge
//  RST_N      in   1      asynchronous, active-low reset
//  in_valid   in   1      upstream word available
//  in_data    in   DW     upstream word
//  in_ready   out  1      buffer not full; word accepted when in_valid&&in_ready
//  clr        in   1      synchronous: flush buffer, zero shadow count, go IDLE
//  enable     out  1      one-cycle request pulse to accumulator
//  value      out  DW     operand to accumulator
//  busy       out  1      FSM not IDLE or buffer non-empty
//  level      out  $clog2(DEPTH)+1  buffer occupancy
//  exp_count  out  DW     shadow of accumulator count
// BEHAVIOUR
//  Reset (RST_N=0, async): buffer empty, FSM IDLE, enable=0, value=0, exp_count=0,
//   in_ready=1, busy=0, level=0.
//  FSM: IDLE -> ISSUE when buffer non-empty; pops head into value register.
//   ISSUE: enable=1 for exactly this cycle -> HOLD_1 .. HOLD_HOLD (enable=0).
//   In last HOLD state: exp_count <= exp_count + value (mod 2^DW, carry dropped);
//   then IDLE if buffer empty, else ISSUE directly (pop next word).
//  Cadence: back-to-back issues are HOLD+1 cycles apart; enable never high on two
//   consecutive cycles. value changes only on entry to ISSUE; otherwise stable.
//  Latency: word written into empty buffer at edge t -> enable high in cycle t+1.
//  Buffer: FIFO order, no reorder/drop. Full: in_ready=0, in_valid ignored.
//   Push and pop in same cycle when full: in_ready stays 0 (decided on registered
//   level), pop proceeds. Push+pop when non-full: level unchanged.
//  Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
//  clr: wins over push/pop in that cycle; enable forced 0; an in-flight word is
//   abandoned (exp_count not updated); value retains last value.
//  Reset mid-operation: everything returns to reset values immediately.
//  No backpressure from accumulator: it is always ready in its IDLE state; the
//   HOLD cadence guarantees that.
// STRUCTURE
//  Package accum_pkg: feeder state enum (IDLE, ISSUE, HOLD), DW default constant.
//  Sub-module sync_fifo (DW, DEPTH): push/pop/full/empty/level, async active-low
//   reset, sync clr. FSM, value register and shadow adder stay in accum_feeder.
// TESTING
//  1 Reset: hold RST_N=0, then release -> all outputs 0, in_ready=1.
//  2 Single word 5 -> enable pulse next cycle, value=5 for 3 cycles, exp_count=5.
//  3 Burst 1,2,3,4 back-to-back -> enables every 3 cycles, values in order,
//    exp_count=10; drive a reference accumulator model, its count must equal 10.
//  4 Fill 9 words with DEPTH=8, no drain possible early -> in_ready=0 at level 8,
//    9th word held by source until a pop, no word lost or duplicated.
//  5 Wrap: exp_count=32'hFFFF_FFFE then word 3 -> exp_count=1.
//  6 clr during HOLD with 3 words buffered -> enable stays 0, level=0,
//    exp_count=0, busy=0 next cycle; async RST_N drop mid-burst same result.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulate feeder.
//   DW_DEFAULT     default width of value and shadow count
//   feeder_state_t issue sequencer states
//   hold_cnt_w     width of the hold-phase down-counter for a given HOLD
package accum_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } feeder_state_t;

  // The hold counter runs HOLD-1 down to 0, so it needs at least one bit.
  function automatic int hold_cnt_w(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/accum_feeder_if.sv
// Handshake bundle of the feeder.
//   in_valid / in_data / in_ready : upstream valid/ready word stream
//   enable / value                : request pulse and operand to the accumulator
// slave  = the feeder (consumes the stream, drives the accumulator side)
// master = the environment (drives the stream, observes the accumulator side)
interface accum_feeder_if #(
  parameter int DW = accum_pkg::DW_DEFAULT
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          enable;
  logic [DW-1:0] value;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  enable,
    input  value
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output enable,
    output value
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush, overrides push and pop
//   push, din  : write request and data (ignored when full)
//   pop, dout  : read request and head-of-queue data (ignored when empty)
//   full, empty, level : status, derived from the registered occupancy
module sync_fifo #(
  parameter  int DW    = 32,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_LVL);
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = mem[rd_ptr];

  // Full is judged on the registered count, so a pop in the same cycle
  // does not open a slot for a push until the next cycle.
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/accum_feeder.sv
// Initiator for the enable/value accumulator. Buffers upstream words and
// issues them one at a time as a single-cycle enable pulse with value held
// stable until the accumulator has added it; tracks the accumulator count
// in a shadow register.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush of buffer, shadow count and sequencer
//   bus        : upstream stream (in_*) and accumulator request (enable/value)
//   busy       : sequencer active or words still buffered
//   level      : buffer occupancy 0..DEPTH
//   exp_count  : shadow of the accumulator count (wraps modulo 2^DW)
//
// state    | meaning
// ST_IDLE  | nothing in flight, waiting for a buffered word
// ST_ISSUE | enable high this cycle, value just loaded
// ST_HOLD  | value held for HOLD cycles; add into shadow on the last one
module accum_feeder
  import accum_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  accum_feeder_if.slave            bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DW-1:0]            exp_count
);

  localparam int             CW        = hold_cnt_w(HOLD);
  localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD - 1);

  feeder_state_t  state;
  logic [CW-1:0]  hold_cnt;
  logic           enable_q;
  logic [DW-1:0]  value_q;

  logic [DW-1:0]  head;
  logic           full;
  logic           empty;
  logic           pop;
  logic           hold_done;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (bus.in_valid),
    .din   (bus.in_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bus.in_ready = !full;
  assign bus.enable   = enable_q;
  assign bus.value    = value_q;
  assign busy         = (state != ST_IDLE) || !empty;

  assign hold_done = (state == ST_HOLD) && (hold_cnt == '0);

  // A word leaves the buffer only when the sequencer is about to enter ISSUE:
  // from IDLE, or straight out of the last hold cycle for back-to-back issue.
  assign pop = !clr && !empty && ((state == ST_IDLE) || hold_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      enable_q  <= 1'b0;
      value_q   <= '0;
      exp_count <= '0;
    end else if (clr) begin
      // In-flight word is dropped without updating the shadow; value keeps
      // its last contents.
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      enable_q  <= 1'b0;
      exp_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            value_q  <= head;
            enable_q <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          enable_q <= 1'b0;
          hold_cnt <= HOLD_LAST;
          state    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            exp_count <= exp_count + value_q;
            if (pop) begin
              value_q  <= head;
              enable_q <= 1'b1;
              state    <= ST_ISSUE;
            end else begin
              state    <= ST_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          enable_q <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_feeder.sv
module tb_accum_feeder;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int HOLD  = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr   = 1'b0;
  logic          busy;
  logic [LW-1:0] level;
  logic [DW-1:0] exp_count;

  accum_feeder_if #(.DW(DW)) bus ();

  accum_feeder #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .HOLD  (HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .bus       (bus.slave),
    .busy      (busy),
    .level     (level),
    .exp_count (exp_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: words accepted upstream must come out in order; the
  // accumulator total is the plain sum of everything accepted since clr/reset.
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] sum_model = '0;
  logic [DW-1:0] ref_acc   = '0;   // accumulator model fed by enable/value
  int            en_times [$];
  int            cyc = 0;
  int            saw_full = 0;
  bit            tracking = 0;
  int            since_en = 0;
  logic [DW-1:0] held_val = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: every enable pulse consumes the next expected word; value must
  // then stay put for HOLD cycles with no further enable.
  always @(negedge clk) begin
    if (!rst_n) begin
      tracking = 0;
    end else if (bus.enable) begin
      if (tracking) fail_now("enable_spacing");
      if (exp_q.size() == 0) fail_now("enable_unexpected");
      else check("value_order", bus.value, exp_q.pop_front());
      ref_acc  = ref_acc + bus.value;
      held_val = bus.value;
      since_en = 0;
      tracking = 1;
      en_times.push_back(cyc);
    end else if (tracking) begin
      since_en++;
      check("value_hold", bus.value, held_val);
      if (since_en == HOLD) tracking = 0;
    end
  end

  task automatic flush_models();
    exp_q.delete();
    sum_model = '0;
    ref_acc   = '0;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    bit got = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      check("in_ready_vs_level", bus.in_ready, level != LW'(DEPTH));
      if (level == LW'(DEPTH)) saw_full++;
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        exp_q.push_back(d);
        sum_model = sum_model + d;
        got = 1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    if (!got) fail_now("push_timeout");
  endtask

  task automatic drain();
    bit idle = 0;
    for (int i = 0; i < 300 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    if (!idle) fail_now("drain_timeout");
    check("drain_queue_empty", exp_q.size(), 0);
    check("exp_count_vs_sum", exp_count, sum_model);
    check("ref_acc_vs_exp_count", ref_acc, exp_count);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    flush_models();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_enable"},    bus.enable, 1'b0);
    check({tag, "_value"},     bus.value, '0);
    check({tag, "_exp_count"}, exp_count, '0);
    check({tag, "_in_ready"},  bus.in_ready, 1'b1);
    check({tag, "_busy"},      busy, 1'b0);
    check({tag, "_level"},     level, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // 1: reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_release");
    @(posedge clk);
    #1;

    // 2: single word, latency and hold window
    push_word(32'd5);
    @(negedge clk);
    check("single_lat_idle", bus.enable, 1'b0);
    @(negedge clk);
    check("single_enable", bus.enable, 1'b1);
    check("single_value0", bus.value, 32'd5);
    for (int k = 1; k <= HOLD; k++) begin
      @(negedge clk);
      check("single_enable_low", bus.enable, 1'b0);
      check("single_value_held", bus.value, 32'd5);
    end
    drain();
    check("single_count", exp_count, 32'd5);

    // 3: burst 1..4, issues exactly HOLD+1 cycles apart
    do_clr();
    en_times.delete();
    for (int k = 1; k <= 4; k++) push_word(DW'(k));
    drain();
    check("burst_count", exp_count, 32'd10);
    check("burst_ref_acc", ref_acc, 32'd10);
    check("burst_enables", en_times.size(), 4);
    for (int k = 1; k < en_times.size(); k++)
      check("burst_cadence", en_times[k] - en_times[k-1], HOLD + 1);

    // 4: overfill, source must stall at level DEPTH
    do_clr();
    saw_full = 0;
    for (int k = 0; k < 14; k++) push_word(DW'(100 + k));
    check("reached_full", saw_full != 0, 1'b1);
    drain();

    // 5: shadow count wraps
    do_clr();
    push_word(32'hFFFF_FFFE);
    drain();
    check("wrap_pre", exp_count, 32'hFFFF_FFFE);
    push_word(32'd3);
    drain();
    check("wrap_post", exp_count, 32'd1);

    // 6a: clr in the last hold cycle with three words buffered
    for (int k = 0; k < 4; k++) push_word(DW'(20 + k));
    check("pre_clr_level", level, LW'(3));
    check("pre_clr_enable", bus.enable, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    flush_models();
    @(negedge clk);
    check("clr_enable", bus.enable, 1'b0);
    check("clr_level", level, '0);
    check("clr_exp_count", exp_count, '0);
    check("clr_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("clr_enable_stays_low", bus.enable, 1'b0);
    end
    @(posedge clk);
    #1;

    // 6b: asynchronous reset mid-burst
    for (int k = 0; k < 4; k++) push_word(DW'(40 + k));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    flush_models();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // random traffic with idle gaps and near-overflow operands
    for (int n = 0; n < 40; n++) begin
      d = $urandom();
      if ($urandom_range(0, 3) == 0) d = 32'hFFFF_FFF0 | DW'($urandom_range(0, 15));
      push_word(d);
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
